tile_sequencer: RTL and testbench

Control FSM sitting directly upstream of the tile counter in the TPU datapath. Accepts a tile job (rows × columns), programs the counter with its load values, keeps it enabled until the counter reports full, then holds for the systolic-array drain latency before signalling completion. Provides the only source of the counter's reset, enable and load controls, plus job-level status (busy, done, err) to the host-side command logic.

---
 rtl/tile_sequencer.sv | 159 +++++++++++++++
 tb/tb_tile_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sequencer.sv
// Tile job sequencer: drives the tile counter's reset, enable and load controls and reports job status.
// Optional RUN-phase watchdog compiled in with `define TILE_SEQ_WATCHDOG_EN.
module tile_sequencer #(
    parameter int CNT_W       = 32,
    parameter int ARRAY_DIM   = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_rows,
    input  logic [CNT_W-1:0] num_cols,
    input  logic             abort,
    input  logic             counter_full,
    output logic             cnt_rst,
    output logic             cnt_enable,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_value,
    output logic [CNT_W-1:0] cnt_load_subvalue,
    output logic             busy,
    output logic             drain_active,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DRAIN_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ARRAY_DIM - 1);

    generate
        if (ARRAY_DIM < 1) begin : g_bad_array_dim
            $error("tile_sequencer: ARRAY_DIM must be at least 1");
        end
        if (WDOG_CYCLES < 1) begin : g_bad_wdog
            $error("tile_sequencer: WDOG_CYCLES must be at least 1");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic               err_nxt;
    logic               capture;
    logic               wdog_expired;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [CNT_W-1:0]   rows_q;
    logic [CNT_W-1:0]   cols_q;

`ifdef TILE_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // Counts consecutive RUN cycles; restarted on every LOAD entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state_nxt == LOAD) begin
            wdog_cnt <= '0;
        end else if (state == RUN) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    assign wdog_expired = (state == RUN) && (wdog_cnt == WDOG_LAST);
`else
    assign wdog_expired = 1'b0;
`endif

    // abort outranks counter_full, drain completion and watchdog expiry.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((num_rows != '0) && (num_cols != '0)) begin
                        state_nxt = LOAD;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nxt = abort ? DONE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (counter_full) begin
                    state_nxt = DRAIN;
                end else if (wdog_expired) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            DRAIN: begin
                if (abort || (drain_cnt == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, captured dimensions and all outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            drain_cnt    <= '0;
            cnt_rst      <= 1'b0;
            cnt_enable   <= 1'b0;
            cnt_load     <= 1'b0;
            busy         <= 1'b0;
            drain_active <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                rows_q <= num_rows;
                cols_q <= num_cols;
            end
            if (state != DRAIN) begin
                drain_cnt <= DRAIN_LAST;
            end else begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
            cnt_rst      <= (state_nxt == DONE);
            cnt_enable   <= (state_nxt == LOAD) || (state_nxt == RUN);
            cnt_load     <= (state_nxt == LOAD);
            busy         <= (state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == DRAIN);
            drain_active <= (state_nxt == DRAIN);
            done         <= (state_nxt == DONE);
            err          <= (state_nxt == DONE) && err_nxt;
        end
    end

    assign cnt_load_value    = rows_q;
    assign cnt_load_subvalue = cols_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed self-checking bench for tile_sequencer (ARRAY_DIM=8, WDOG_CYCLES=16).
// Build with +define+TILE_SEQ_WATCHDOG_EN to exercise the watchdog expiry path.
module tb_tile_sequencer;

    localparam int CNT_W = 32;

    // Control vector order: {cnt_rst, cnt_enable, cnt_load, busy, drain_active, done, err}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_LOAD  = 7'b0111000;
    localparam logic [6:0] V_RUN   = 7'b0101000;
    localparam logic [6:0] V_DRAIN = 7'b0001100;
    localparam logic [6:0] V_DONE  = 7'b1000010;
    localparam logic [6:0] V_DERR  = 7'b1000011;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_rows;
    logic [CNT_W-1:0] num_cols;
    logic             abort;
    logic             counter_full;
    logic             cnt_rst;
    logic             cnt_enable;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic [CNT_W-1:0] cnt_load_subvalue;
    logic             busy;
    logic             drain_active;
    logic             done;
    logic             err;
    logic [6:0]       ctl;

    int errors = 0;
    int checks = 0;

    tile_sequencer #(
        .CNT_W       (CNT_W),
        .ARRAY_DIM   (8),
        .WDOG_CYCLES (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_rows          (num_rows),
        .num_cols          (num_cols),
        .abort             (abort),
        .counter_full      (counter_full),
        .cnt_rst           (cnt_rst),
        .cnt_enable        (cnt_enable),
        .cnt_load          (cnt_load),
        .cnt_load_value    (cnt_load_value),
        .cnt_load_subvalue (cnt_load_subvalue),
        .busy              (busy),
        .drain_active      (drain_active),
        .done              (done),
        .err               (err)
    );

    assign ctl = {cnt_rst, cnt_enable, cnt_load, busy, drain_active, done, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        num_rows = '0;
        num_cols = '0;
        abort = 1'b0;
        counter_full = 1'b0;
        tick();
        tick();
        checks++;
        if (ctl !== V_IDLE) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, V_IDLE);
        end
        checks++;
        if (cnt_load_value !== 32'd0 || cnt_load_subvalue !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got %0d/%0d expected 0/0", cnt_load_value, cnt_load_subvalue);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ctl !== V_IDLE) begin
            errors++;
            $display("FAIL reset_release_ctl: got %b expected %b", ctl, V_IDLE);
        end
    endtask

    // counter_full in cycle 7 -> DRAIN 8..15, DONE 16, IDLE 17.
    task automatic test_normal_job();
        logic [6:0] exp;
        start = 1'b1;
        num_rows = 32'd2;
        num_cols = 32'd3;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1) exp = V_LOAD;
            else if (c <= 7) exp = V_RUN;
            else if (c <= 15) exp = V_DRAIN;
            else if (c == 16) exp = V_DONE;
            else exp = V_IDLE;
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL normal_c%0d: got %b expected %b", c, ctl, exp);
            end
            if (c == 1 || c == 16 || c == 17) begin
                checks++;
                if (cnt_load_value !== 32'd2 || cnt_load_subvalue !== 32'd3) begin
                    errors++;
                    $display("FAIL normal_values_c%0d: got %0d/%0d expected 2/3", c, cnt_load_value, cnt_load_subvalue);
                end
            end
            start = 1'b0;
            num_rows = 32'd9;
            num_cols = 32'd9;
            counter_full = (c == 7);
        end
        counter_full = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        num_rows = 32'd4;
        num_cols = 32'd6;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (ctl !== V_RUN) begin
            errors++;
            $display("FAIL midrun_before: got %b expected %b", ctl, V_RUN);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== V_IDLE || cnt_load_value !== 32'd0 || cnt_load_subvalue !== 32'd0) begin
            errors++;
            $display("FAIL midrun_async: got %b %0d/%0d expected %b 0/0", ctl, cnt_load_value, cnt_load_subvalue, V_IDLE);
        end
        tick();
        checks++;
        if (ctl !== V_IDLE) begin
            errors++;
            $display("FAIL midrun_held: got %b expected %b", ctl, V_IDLE);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: got %b expected 0", done);
        end
        start = 1'b1;
        num_rows = 32'd3;
        num_cols = 32'd5;
        tick();
        start = 1'b0;
        checks++;
        if (ctl !== V_LOAD || cnt_load_value !== 32'd3 || cnt_load_subvalue !== 32'd5) begin
            errors++;
            $display("FAIL midrun_restart: got %b %0d/%0d expected %b 3/5", ctl, cnt_load_value, cnt_load_subvalue, V_LOAD);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (ctl !== V_DONE) begin
            errors++;
            $display("FAIL midrun_abort_load: got %b expected %b", ctl, V_DONE);
        end
        tick();
    endtask

    task automatic test_zero_dim();
        logic [CNT_W-1:0] rows_t [2];
        logic [CNT_W-1:0] cols_t [2];
        rows_t[0] = 32'd0; cols_t[0] = 32'd5;
        rows_t[1] = 32'd7; cols_t[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            num_rows = rows_t[i];
            num_cols = cols_t[i];
            tick();
            start = 1'b0;
            checks++;
            if (ctl !== V_DERR) begin
                errors++;
                $display("FAIL zero_dim_%0d_done: got %b expected %b", i, ctl, V_DERR);
            end
            tick();
            checks++;
            if (ctl !== V_IDLE) begin
                errors++;
                $display("FAIL zero_dim_%0d_idle: got %b expected %b", i, ctl, V_IDLE);
            end
        end
    endtask

    task automatic test_abort();
        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (ctl !== V_IDLE) begin
            errors++;
            $display("FAIL abort_idle: got %b expected %b", ctl, V_IDLE);
        end
        // abort together with counter_full in RUN cycle 3
        start = 1'b1;
        num_rows = 32'd1;
        num_cols = 32'd1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            if (c == 4) begin
                checks++;
                if (ctl !== V_DONE) begin
                    errors++;
                    $display("FAIL abort_prio_done: got %b expected %b", ctl, V_DONE);
                end
            end
            checks++;
            if (drain_active !== 1'b0) begin
                errors++;
                $display("FAIL abort_prio_drain_c%0d: got %b expected 0", c, drain_active);
            end
            abort = (c == 3);
            counter_full = (c == 3);
        end
        // abort during DRAIN: counter_full cycle 2, DRAIN from 3, abort in 5 -> DONE in 6
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
            if (c == 5) begin
                checks++;
                if (ctl !== V_DRAIN) begin
                    errors++;
                    $display("FAIL abort_drain_pre: got %b expected %b", ctl, V_DRAIN);
                end
            end
            if (c == 6) begin
                checks++;
                if (ctl !== V_DONE) begin
                    errors++;
                    $display("FAIL abort_drain_done: got %b expected %b", ctl, V_DONE);
                end
            end
            counter_full = (c == 2);
            abort = (c == 5);
        end
        abort = 1'b0;
        counter_full = 1'b0;
    endtask

    // start held high: DONE in 11, IDLE in 12, second LOAD in 13 with dims changed during busy.
    task automatic test_back_to_back();
        logic [6:0] exp;
        start = 1'b1;
        num_rows = 32'd1;
        num_cols = 32'd2;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1 || c == 13) exp = V_LOAD;
            else if (c == 2) exp = V_RUN;
            else if (c <= 10) exp = V_DRAIN;
            else if (c == 11 || c == 14) exp = V_DONE;
            else exp = V_IDLE;
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL b2b_c%0d: got %b expected %b", c, ctl, exp);
            end
            if (c == 11 || c == 13) begin
                checks++;
                if (c == 11 && (cnt_load_value !== 32'd1 || cnt_load_subvalue !== 32'd2)) begin
                    errors++;
                    $display("FAIL b2b_values_first: got %0d/%0d expected 1/2", cnt_load_value, cnt_load_subvalue);
                end
                if (c == 13 && (cnt_load_value !== 32'd7 || cnt_load_subvalue !== 32'd5)) begin
                    errors++;
                    $display("FAIL b2b_values_second: got %0d/%0d expected 7/5", cnt_load_value, cnt_load_subvalue);
                end
            end
            if (c == 1) begin
                num_rows = 32'd7;
                num_cols = 32'd5;
            end
            counter_full = (c == 2);
            abort = (c == 13);
            start = (c < 13);
        end
        abort = 1'b0;
    endtask

    task automatic test_watchdog();
        start = 1'b1;
        num_rows = 32'd2;
        num_cols = 32'd2;
`ifdef TILE_SEQ_WATCHDOG_EN
        // RUN cycles 2..17, expiry DONE/err in 18
        for (int c = 1; c <= 19; c++) begin
            tick();
            start = 1'b0;
            if (c == 17) begin
                checks++;
                if (ctl !== V_RUN) begin
                    errors++;
                    $display("FAIL wdog_last_run: got %b expected %b", ctl, V_RUN);
                end
            end
            if (c == 18) begin
                checks++;
                if (ctl !== V_DERR) begin
                    errors++;
                    $display("FAIL wdog_expiry: got %b expected %b", ctl, V_DERR);
                end
            end
            if (c == 19) begin
                checks++;
                if (ctl !== V_IDLE) begin
                    errors++;
                    $display("FAIL wdog_idle: got %b expected %b", ctl, V_IDLE);
                end
            end
        end
`else
        for (int c = 1; c <= 120; c++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (ctl !== V_RUN) begin
            errors++;
            $display("FAIL no_wdog_busy: got %b expected %b", ctl, V_RUN);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (ctl !== V_DONE) begin
            errors++;
            $display("FAIL no_wdog_abort: got %b expected %b", ctl, V_DONE);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_normal_job();
        test_reset_mid_run();
        test_zero_dim();
        test_abort();
        test_back_to_back();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
